// File: rtl/dmem_vec_resp.sv
// ============================================================================
// dmem_vec_resp : multi-cycle scalar/vector data-memory responder on a 32-bit
//                 single-port word array. Revision 1.0
// ============================================================================
`default_nettype none

module dmem_vec_resp #(
  parameter int VLEN  = 128,
  parameter int DEPTH = 1024,
  parameter int IW    = 10
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [31:0]     addr,
  input  logic [VLEN-1:0] wdata,
  input  logic [3:0]      wmem,
  input  logic            vector,
  output logic [VLEN-1:0] rdata,
  output logic            rsp_valid
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SBEAT = 2'd1;
  localparam logic [1:0] VBEAT = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [1:0]      beat_q, beat_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [VLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      wmem_q, wmem_d;
  logic [VLEN-1:0] rdata_q, rdata_d;
  logic [31:0]     mem_q [DEPTH];

  logic            accept;
  logic            mem_we;
  logic [IW-1:0]   acc_idx;
  logic [31:0]     rd_word;
  logic [31:0]     wr_lane;
  logic            unused_addr;

  // Byte offset and high address bits are discarded: word-aligned, wraps mod DEPTH.
  assign unused_addr = ^{addr[31:IW+2], addr[1:0]};

  assign req_ready = ~clrn & ((state_q == IDLE) | (state_q == RESP));
  assign rsp_valid = ~clrn & (state_q == RESP);
  assign rdata     = clrn ? '0 : rdata_q;
  assign accept    = req_valid & req_ready;

  assign acc_idx = idx_q + {{(IW-2){1'b0}}, beat_q};
  assign rd_word = mem_q[acc_idx];
  assign wr_lane = wdata_q[{beat_q, 5'd0} +: 32];

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wmem_d  = wmem_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (accept) begin
          idx_d   = addr[IW+1:2];
          wdata_d = wdata;
          wmem_d  = wmem;
          beat_d  = 2'd0;
          state_d = vector ? VBEAT : SBEAT;
        end
      end
      SBEAT: begin
        if (wmem_q == 4'd0) rdata_d = {{(VLEN-32){1'b0}}, rd_word};
        else                mem_we  = 1'b1;
        state_d = RESP;
      end
      VBEAT: begin
        if (wmem_q == 4'd0) rdata_d[{beat_q, 5'd0} +: 32] = rd_word;
        else                mem_we = 1'b1;
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
    // Reset aborts the in-flight beat, so its write must not land.
    if (clrn) mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (clrn) begin
      state_q <= IDLE;
      beat_q  <= 2'd0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
    wmem_q  <= wmem_d;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (wmem_q[k]) mem_q[acc_idx][8*k +: 8] <= wr_lane[8*k +: 8];
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/dmem_vec_resp.md
Name: dmem_vec_resp

Overview:
- Multi-cycle data-memory responder for the RV32IMV AES core's load/store port.
- Accepts scalar (32-bit) and vector (VLEN-bit) requests over a valid/ready handshake.
- Serves requests from a 32-bit-wide word array, so a 128-bit vector access takes four sequential word beats.
- Replaces the single-cycle wide data memory so the array can map to single-port 32-bit block RAM.

Parameters:
VLEN, 128, vector register width in bits; must be 4*32 in this revision
DEPTH, 1024, number of 32-bit words in the array; power of two
IW, 10, word index width, log2(DEPTH)

Ports:
clk  in  1  system clock, all state on rising edge
clrn  in  1  reset, synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
addr  in  32  byte address (ALU output)
wdata  in  VLEN  store data; scalar uses [31:0]
wmem  in  4  byte write enables; 0 = load, nonzero = store
vector  in  1  1 = VLEN-bit access, 0 = 32-bit access
rdata  out  VLEN  load data
rsp_valid  out  1  one-cycle completion pulse

Behaviour:
- Reset: clrn is synchronous and active-high. While asserted, the block drives state=IDLE, beat=0, rsp_valid=0, rdata=0 and req_ready=0. Array contents are not reset.
- Reset mid-operation: any in-flight request is aborted. Remaining vector beats are not written, no rsp_valid is issued, and words already written stay written.
- States: IDLE, SBEAT, VBEAT, RESP.
- req_ready=1 in IDLE and RESP, 0 otherwise.
- Acceptance: a request is accepted when req_valid & req_ready at a rising edge. At acceptance the block latches addr, wdata, wmem and vector.
- Word index: idx = addr[IW+1:2]. addr[1:0] and addr bits above IW+1 are ignored, so accesses are forced word-aligned and wrap modulo DEPTH.
- Scalar access (vector=0): accept -> SBEAT. SBEAT lasts one cycle and performs one array access at idx, then -> RESP.
  - Store: for each byte k with wmem[k]=1, write wdata[8k+7:8k] to that byte of word idx.
  - Load: rdata <= {(VLEN-32) zeros, mem[idx]}.
- Vector access (vector=1): accept -> VBEAT with beat=0. VBEAT performs one array access per cycle at (idx+beat) mod DEPTH for beat=0..3. After beat 3 the state -> RESP.
  - Store: word (idx+beat) receives wdata[32*beat+31:32*beat], byte-masked by wmem.
  - Load: rdata[32*beat+31:32*beat] <= mem[(idx+beat) mod DEPTH]. rdata lanes are updated as beats complete; they are only guaranteed valid when rsp_valid=1.
- RESP: rsp_valid=1 for exactly one cycle. Next state is IDLE, unless a new request is accepted in the same cycle, in which case the next state is SBEAT or VBEAT.
- Latency from acceptance edge to the rsp_valid cycle: scalar 2 cycles, vector 5 cycles. Back-to-back scalar throughput is one request per 2 cycles.
- Stores also pulse rsp_valid. rdata holds its previous value on stores.
- Inputs are ignored while req_ready=0. No request queueing.
- Read and write on the same beat cannot occur, since one request is either a load or a store.
- Wrap-around: a vector access at idx=DEPTH-1 touches words DEPTH-1, 0, 1, 2.
- The array is a single-port, 32-bit synchronous-write register/BRAM array. Reads may be combinational within the beat, provided rdata is registered.

Test Plan:
- Reset with clrn=1 for 2 cycles, then release -> rsp_valid=0, rdata=0, req_ready=0 during reset; req_ready=1 on the first cycle after release.
- Scalar store addr=0x10, wdata=0xDEADBEEF, wmem=4'b1111, then scalar load addr=0x10 -> rsp_valid 2 cycles after each acceptance; rdata=0x...00000000DEADBEEF. Repeat the store with wmem=4'b0010, wdata=0x0000AA00 -> load returns 0xDEADAAEF.
- Vector store addr=0x100, wdata=0x33333333_22222222_11111111_00000000, wmem=4'hF, then vector load addr=0x100 -> rsp_valid exactly 5 cycles after acceptance; rdata equals the stored value; scalar load addr=0x108 returns 0x22222222.
- Vector store at addr=(DEPTH-1)*4 with lanes A,B,C,D -> scalar loads of words DEPTH-1, 0, 1, 2 return A, B, C, D.
- Hold req_valid=1 with a new request during VBEAT -> req_ready=0 and the request is not accepted. Present it in the RESP cycle -> accepted in RESP, with no idle cycle between responses.
- Assert clrn at vector-store beat 2 -> words idx and idx+1 are updated, words idx+2 and idx+3 are unchanged, no rsp_valid, and the block is in IDLE after release.
